// File: rtl/ipv4_parser_pkg.sv
// Shared types and constants for the IPv4 receive path.
// Provides byte/address types, IPv4 header field constants, the parser state
// encoding and a helper that returns the index of the last header byte.
package ipv4_parser_pkg;

  typedef logic [7:0]  byte_t;
  typedef logic [31:0] ipv4_addr_t;

  localparam logic [3:0] IPV4_VERSION   = 4'd4;
  localparam logic [3:0] IPV4_MIN_IHL   = 4'd5;
  localparam logic [7:0] IPV4_PROTO_UDP = 8'd17;
  localparam ipv4_addr_t IPV4_BCAST     = 32'hFFFF_FFFF;

  // Byte offsets of header fields
  localparam logic [5:0] IPV4_TLEN_POS  = 6'd2;
  localparam logic [5:0] IPV4_FLAGS_POS = 6'd6;
  localparam logic [5:0] IPV4_PROTO_POS = 6'd9;
  localparam logic [5:0] IPV4_SRC_POS   = 6'd12;
  localparam logic [5:0] IPV4_DST_POS   = 6'd16;

  typedef enum logic [1:0] {
    StHdr,
    StPayload,
    StPad,
    StDrop
  } ipv4_state_e;

  // An IHL below the minimum still ends the header at the minimum length so
  // that the header can be rejected at a well-defined point.
  function automatic logic [5:0] hdr_last_idx(logic [3:0] ihl);
    return (ihl < IPV4_MIN_IHL) ? (IPV4_DST_POS + 6'd3) : ({ihl, 2'b00} - 6'd1);
  endfunction

endpackage

// File: rtl/ipv4_csum_acc.sv
// IPv4 header checksum accumulator.
// Pairs incoming bytes into big-endian 16-bit words and keeps a ones-complement
// sum with end-around carry applied on every word.
//  clk, rst    : clock, synchronous active-high reset
//  clr         : restart the sum (takes effect next cycle)
//  byte_valid  : byte_in is a header byte
//  byte_in     : header byte
//  sum_ok      : sum including the word completed this cycle equals 16'hFFFF
module ipv4_csum_acc
  import ipv4_parser_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clr,
  input  logic  byte_valid,
  input  byte_t byte_in,
  output logic  sum_ok
);

  logic [15:0] sum_q, sum_d;
  logic        odd_q, odd_d;
  byte_t       msb_q, msb_d;
  logic [16:0] add;
  logic [15:0] folded;
  logic [15:0] sum_now;

  always_comb begin
    add     = {1'b0, sum_q} + {1'b0, msb_q, byte_in};
    folded  = add[15:0] + {15'd0, add[16]};
    // Look-ahead so the final header byte is already part of the verdict
    sum_now = (byte_valid && odd_q) ? folded : sum_q;
    sum_ok  = (sum_now == 16'hFFFF);

    sum_d = sum_q;
    odd_d = odd_q;
    msb_d = msb_q;
    if (clr) begin
      sum_d = '0;
      odd_d = 1'b0;
      msb_d = '0;
    end else if (byte_valid) begin
      if (odd_q) begin
        sum_d = folded;
        odd_d = 1'b0;
      end else begin
        msb_d = byte_in;
        odd_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
      odd_q <= 1'b0;
      msb_q <= '0;
    end else begin
      sum_q <= sum_d;
      odd_q <= odd_d;
      msb_q <= msb_d;
    end
  end

endmodule

// File: rtl/ipv4_parser.sv
// IPv4 header parser / stripper.
// Validates the IPv4 header (options included), removes it and any trailing
// Ethernet padding, and forwards payload bytes with header metadata. One byte
// is held back so frame-end status can be attached to the last payload byte.
//  clk, rst                          : clock, synchronous active-high reset
//  eth_data_in/byte_valid/eof/err    : byte stream from the Ethernet stage
//  ip_data_out/byte_valid/eof/err    : payload byte stream (registered)
//  ip_meta_valid                     : header accepted pulse
//  ip_src_addr/dst_addr/payload_len  : metadata, held until next accepted header
module ipv4_parser
  import ipv4_parser_pkg::*;
#(
  parameter logic [7:0] PROTOCOL  = IPV4_PROTO_UDP,
  parameter ipv4_addr_t LOCAL_IP  = 32'hC0A8_0164,
  parameter bit         CHECK_DST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  byte_t       eth_data_in,
  input  logic        eth_byte_valid,
  input  logic        eth_eof,
  input  logic        eth_err,
  output byte_t       ip_data_out,
  output logic        ip_byte_valid,
  output logic        ip_eof,
  output logic        ip_err,
  output logic        ip_meta_valid,
  output ipv4_addr_t  ip_src_addr,
  output ipv4_addr_t  ip_dst_addr,
  output logic [15:0] ip_payload_len
);

  ipv4_state_e state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [3:0]  ver_q, ver_d, ihl_q, ihl_d;
  logic [15:0] tlen_q, tlen_d;
  logic [13:0] frag_q, frag_d;     // MF bit + fragment offset
  logic [7:0]  proto_q, proto_d;
  ipv4_addr_t  src_q, src_d, dst_q, dst_d;
  logic [15:0] rem_q, rem_d;
  byte_t       hold_q, hold_d;
  logic        hold_vld_q, hold_vld_d;
  logic        flush_q, flush_d, flush_err_q, flush_err_d;
  byte_t       out_data_q, out_data_d;
  logic        out_vld_q, out_vld_d, out_eof_q, out_eof_d, out_err_q, out_err_d;
  logic        meta_q, meta_d;
  ipv4_addr_t  src_out_q, src_out_d, dst_out_q, dst_out_d;
  logic [15:0] len_q, len_d;

  logic        data_beat, eof_beat, csum_clr, csum_vld, sum_ok, hdr_bad;
  logic [5:0]  hdr_len;
  logic [15:0] plen;
  ipv4_addr_t  dst_cur;

  ipv4_csum_acc u_csum (
    .clk        (clk),
    .rst        (rst),
    .clr        (csum_clr),
    .byte_valid (csum_vld),
    .byte_in    (eth_data_in),
    .sum_ok     (sum_ok)
  );

  always_comb begin
    eof_beat  = eth_byte_valid && eth_eof;
    data_beat = eth_byte_valid && !(eth_eof && eth_err);
    hdr_len   = {ihl_q, 2'b00};
    plen      = tlen_q - {10'd0, hdr_len};
    // With IHL=5 the last destination byte is the current input byte
    dst_cur   = (cnt_q == IPV4_DST_POS + 6'd3) ? {dst_q[23:0], eth_data_in} : dst_q;
    hdr_bad   = (ver_q != IPV4_VERSION) || (ihl_q < IPV4_MIN_IHL) || !sum_ok ||
                (frag_q != '0) || (proto_q != PROTOCOL) ||
                (CHECK_DST && (dst_cur != LOCAL_IP) && (dst_cur != IPV4_BCAST)) ||
                (tlen_q <= {10'd0, hdr_len});

    state_d     = state_q;
    cnt_d       = cnt_q;
    ver_d       = ver_q;
    ihl_d       = ihl_q;
    tlen_d      = tlen_q;
    frag_d      = frag_q;
    proto_d     = proto_q;
    src_d       = src_q;
    dst_d       = dst_q;
    rem_d       = rem_q;
    hold_d      = hold_q;
    hold_vld_d  = hold_vld_q;
    flush_d     = 1'b0;
    flush_err_d = 1'b0;
    out_data_d  = '0;
    out_vld_d   = 1'b0;
    out_eof_d   = 1'b0;
    out_err_d   = 1'b0;
    meta_d      = 1'b0;
    src_out_d   = src_out_q;
    dst_out_d   = dst_out_q;
    len_d       = len_q;
    csum_clr    = 1'b0;
    csum_vld    = 1'b0;

    // Deferred last payload byte; only ever pending while back in StHdr
    if (flush_q) begin
      out_vld_d  = 1'b1;
      out_data_d = hold_q;
      out_eof_d  = 1'b1;
      out_err_d  = flush_err_q;
      hold_vld_d = 1'b0;
    end

    unique case (state_q)
      StHdr: begin
        if (eth_byte_valid) begin
          if (eth_eof || eth_err) begin
            out_err_d = 1'b1;
            cnt_d     = '0;
            csum_clr  = 1'b1;
          end else begin
            csum_vld = 1'b1;
            cnt_d    = cnt_q + 6'd1;
            if (cnt_q == 6'd0) begin
              ver_d = eth_data_in[7:4];
              ihl_d = eth_data_in[3:0];
            end
            if (cnt_q == IPV4_TLEN_POS || cnt_q == IPV4_TLEN_POS + 6'd1) begin
              tlen_d = {tlen_q[7:0], eth_data_in};
            end
            if (cnt_q == IPV4_FLAGS_POS) frag_d[13:8] = eth_data_in[5:0];
            if (cnt_q == IPV4_FLAGS_POS + 6'd1) frag_d[7:0] = eth_data_in;
            if (cnt_q == IPV4_PROTO_POS) proto_d = eth_data_in;
            if (cnt_q >= IPV4_SRC_POS && cnt_q < IPV4_SRC_POS + 6'd4) begin
              src_d = {src_q[23:0], eth_data_in};
            end
            if (cnt_q >= IPV4_DST_POS && cnt_q < IPV4_DST_POS + 6'd4) begin
              dst_d = {dst_q[23:0], eth_data_in};
            end
            if (cnt_q == hdr_last_idx(ihl_q)) begin
              cnt_d    = '0;
              csum_clr = 1'b1;
              if (hdr_bad) begin
                out_err_d = 1'b1;
                state_d   = StDrop;
              end else begin
                meta_d    = 1'b1;
                src_out_d = src_q;
                dst_out_d = dst_cur;
                len_d     = plen;
                rem_d     = plen;
                state_d   = StPayload;
              end
            end
          end
        end
      end
      StPayload: begin
        if (data_beat) begin
          if (hold_vld_q) begin
            out_vld_d  = 1'b1;
            out_data_d = hold_q;
          end
          hold_d     = eth_data_in;
          hold_vld_d = 1'b1;
          rem_d      = rem_q - 16'd1;
          if (eth_eof) begin
            // Byte just taken is the last one; it goes out next cycle
            flush_d     = 1'b1;
            flush_err_d = (rem_q != 16'd1);
            state_d     = StHdr;
          end else if (rem_q == 16'd1) begin
            state_d = StPad;
          end
        end else if (eof_beat) begin
          // CRC-fail end beat before the payload completed
          if (hold_vld_q) begin
            out_vld_d  = 1'b1;
            out_data_d = hold_q;
            out_eof_d  = 1'b1;
            hold_vld_d = 1'b0;
          end
          out_err_d = 1'b1;
          state_d   = StHdr;
        end
      end
      StPad: begin
        if (eof_beat) begin
          out_vld_d  = 1'b1;
          out_data_d = hold_q;
          out_eof_d  = 1'b1;
          out_err_d  = eth_err;
          hold_vld_d = 1'b0;
          state_d    = StHdr;
        end
      end
      StDrop: begin
        if (eof_beat) state_d = StHdr;
      end
      default: state_d = StHdr;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StHdr;
      cnt_q       <= '0;
      ver_q       <= '0;
      ihl_q       <= '0;
      tlen_q      <= '0;
      frag_q      <= '0;
      proto_q     <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      rem_q       <= '0;
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
      flush_q     <= 1'b0;
      flush_err_q <= 1'b0;
      out_data_q  <= '0;
      out_vld_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      out_err_q   <= 1'b0;
      meta_q      <= 1'b0;
      src_out_q   <= '0;
      dst_out_q   <= '0;
      len_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ver_q       <= ver_d;
      ihl_q       <= ihl_d;
      tlen_q      <= tlen_d;
      frag_q      <= frag_d;
      proto_q     <= proto_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      rem_q       <= rem_d;
      hold_q      <= hold_d;
      hold_vld_q  <= hold_vld_d;
      flush_q     <= flush_d;
      flush_err_q <= flush_err_d;
      out_data_q  <= out_data_d;
      out_vld_q   <= out_vld_d;
      out_eof_q   <= out_eof_d;
      out_err_q   <= out_err_d;
      meta_q      <= meta_d;
      src_out_q   <= src_out_d;
      dst_out_q   <= dst_out_d;
      len_q       <= len_d;
    end
  end

  assign ip_data_out    = out_data_q;
  assign ip_byte_valid  = out_vld_q;
  assign ip_eof         = out_eof_q;
  assign ip_err         = out_err_q;
  assign ip_meta_valid  = meta_q;
  assign ip_src_addr    = src_out_q;
  assign ip_dst_addr    = dst_out_q;
  assign ip_payload_len = len_q;

endmodule

// File: tb/tb_ipv4_parser.sv
// Self-checking bench for ipv4_parser: directed frames followed by random
// frames, each compared against a frame-level reference model.
module tb_ipv4_parser;

  localparam logic [31:0] LOCAL_IP = 32'hC0A8_0164;
  localparam logic [31:0] BCAST    = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  eth_data_in;
  logic        eth_byte_valid, eth_eof, eth_err;
  logic [7:0]  ip_data_out;
  logic        ip_byte_valid, ip_eof, ip_err, ip_meta_valid;
  logic [31:0] ip_src_addr, ip_dst_addr;
  logic [15:0] ip_payload_len;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ipv4_parser #(
    .PROTOCOL  (8'd17),
    .LOCAL_IP  (LOCAL_IP),
    .CHECK_DST (1'b1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .eth_data_in    (eth_data_in),
    .eth_byte_valid (eth_byte_valid),
    .eth_eof        (eth_eof),
    .eth_err        (eth_err),
    .ip_data_out    (ip_data_out),
    .ip_byte_valid  (ip_byte_valid),
    .ip_eof         (ip_eof),
    .ip_err         (ip_err),
    .ip_meta_valid  (ip_meta_valid),
    .ip_src_addr    (ip_src_addr),
    .ip_dst_addr    (ip_dst_addr),
    .ip_payload_len (ip_payload_len)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: cumulative record of everything the DUT emits
  logic [7:0]  mon_data [0:8191];
  logic        mon_beof [0:8191];
  logic        mon_berr [0:8191];
  int          mon_nbytes = 0, mon_nerr = 0, mon_neof = 0, mon_nmeta = 0, mon_meta_cyc = 0;
  logic [31:0] mon_src = '0, mon_dst = '0;
  logic [15:0] mon_len = '0;

  always @(negedge clk) begin
    if (ip_byte_valid) begin
      if (mon_nbytes < 8192) begin
        mon_data[mon_nbytes] <= ip_data_out;
        mon_beof[mon_nbytes] <= ip_eof;
        mon_berr[mon_nbytes] <= ip_err;
      end
      mon_nbytes <= mon_nbytes + 1;
    end
    if (ip_eof) mon_neof <= mon_neof + 1;
    if (ip_err) mon_nerr <= mon_nerr + 1;
    if (ip_meta_valid) begin
      mon_nmeta    <= mon_nmeta + 1;
      mon_meta_cyc <= cyc;
      mon_src      <= ip_src_addr;
      mon_dst      <= ip_dst_addr;
      mon_len      <= ip_payload_len;
    end
  end

  logic [7:0]  frm [$];
  logic [7:0]  exp_q [$];
  logic [31:0] frm_src;
  bit          exp_meta, exp_err;
  logic [31:0] exp_src, exp_dst;
  int          exp_len, hdr_cyc;
  int          b0, e0, f0, m0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] d, input logic v, input logic e, input logic r);
    eth_data_in    = d;
    eth_byte_valid = v;
    eth_eof        = e;
    eth_err        = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(8'($urandom), 1'b0, 1'b0, 1'b0);
  endtask

  // Header (with correct checksum unless flip), npay payload bytes, npad pad bytes
  task automatic build(input logic [3:0] ver, input logic [3:0] ihl, input int tlen,
                       input logic [7:0] proto, input logic [15:0] frag, input logic [31:0] dst,
                       input int npay, input int npad, input bit flip);
    int nb, s;
    logic [15:0] ck, tl;
    nb      = (ihl < 4'd5) ? 20 : 4 * int'(ihl);
    frm_src = $urandom;
    tl      = 16'(tlen);
    frm.delete();
    for (int i = 0; i < nb; i++) frm.push_back(8'($urandom));
    frm[0]  = {ver, ihl};
    frm[2]  = tl[15:8];
    frm[3]  = tl[7:0];
    frm[6]  = frag[15:8];
    frm[7]  = frag[7:0];
    frm[8]  = 8'd64;
    frm[9]  = proto;
    frm[10] = 8'h00;
    frm[11] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      frm[12 + i] = frm_src[31 - 8 * i -: 8];
      frm[16 + i] = dst[31 - 8 * i -: 8];
    end
    s = 0;
    for (int i = 0; i < nb; i += 2) s += int'({frm[i], frm[i + 1]});
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >>> 16);
    ck      = ~s[15:0];
    frm[10] = ck[15:8];
    frm[11] = ck[7:0];
    if (flip) frm[10] = frm[10] ^ 8'h01;
    for (int i = 0; i < npay + npad; i++) frm.push_back(8'($urandom));
  endtask

  // Frame-level expectations from the header rules
  task automatic model(input bit crc);
    int n, ihl, hlen, s, tlen, avail;
    logic [15:0] frag;
    logic [31:0] dst;
    bit ok;
    n        = frm.size();
    ihl      = int'(frm[0][3:0]);
    hlen     = (ihl < 5) ? 20 : ihl * 4;
    exp_q.delete();
    exp_meta = 1'b0;
    exp_err  = 1'b0;
    if (n < hlen || (n == hlen && !crc)) begin
      exp_err = 1'b1;
      return;
    end
    s = 0;
    for (int i = 0; i < hlen; i += 2) s += int'({frm[i], frm[i + 1]});
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >>> 16);
    tlen = int'({frm[2], frm[3]});
    frag = {frm[6], frm[7]};
    dst  = {frm[16], frm[17], frm[18], frm[19]};
    ok = (frm[0][7:4] == 4'd4) && (ihl >= 5) && (s == 32'hFFFF) && !frag[13] &&
         (frag[12:0] == 13'd0) && (frm[9] == 8'd17) && (dst == LOCAL_IP || dst == BCAST) &&
         (tlen > hlen);
    if (!ok) begin
      exp_err = 1'b1;
      return;
    end
    exp_meta = 1'b1;
    exp_src  = {frm[12], frm[13], frm[14], frm[15]};
    exp_dst  = dst;
    exp_len  = tlen - hlen;
    avail    = n - hlen;
    if (avail >= exp_len) begin
      for (int i = 0; i < exp_len; i++) exp_q.push_back(frm[hlen + i]);
      exp_err = crc;
    end else begin
      for (int i = 0; i < avail; i++) exp_q.push_back(frm[hlen + i]);
      exp_err = 1'b1;
    end
  endtask

  task automatic send(input bit crc, input int gap_pct);
    int hl;
    hl = (frm[0][3:0] < 4'd5) ? 20 : 4 * int'(frm[0][3:0]);
    for (int i = 0; i < frm.size(); i++) begin
      while (int'($urandom_range(99)) < gap_pct) idle(1);
      drive(frm[i], 1'b1, (i == frm.size() - 1) && !crc, 1'b0);
      if (i == hl - 1) hdr_cyc = cyc;
    end
    if (crc) drive(8'($urandom), 1'b1, 1'b1, 1'b1);
    idle(4);
  endtask

  task automatic snap();
    b0 = mon_nbytes;
    e0 = mon_nerr;
    f0 = mon_neof;
    m0 = mon_nmeta;
  endtask

  task automatic run_frame(input string tag, input bit crc, input int gap_pct);
    int nb, bad, ne;
    model(crc);
    snap();
    send(crc, gap_pct);
    nb  = mon_nbytes - b0;
    ne  = exp_q.size();
    bad = 0;
    for (int i = 0; i < nb && i < ne; i++) if (mon_data[b0 + i] !== exp_q[i]) bad++;
    chk({tag, "_nbytes"}, nb, ne);
    chk({tag, "_data"}, bad, 0);
    chk({tag, "_neof"}, mon_neof - f0, (ne > 0) ? 1 : 0);
    chk({tag, "_nerr"}, mon_nerr - e0, exp_err);
    chk({tag, "_nmeta"}, mon_nmeta - m0, exp_meta);
    if (ne > 0 && nb > 0) begin
      chk({tag, "_eof_last"}, mon_beof[b0 + nb - 1], 1'b1);
      chk({tag, "_err_last"}, mon_berr[b0 + nb - 1], exp_err);
    end
    if (exp_meta) begin
      chk({tag, "_src"}, mon_src, exp_src);
      chk({tag, "_dst"}, mon_dst, exp_dst);
      chk({tag, "_len"}, mon_len, exp_len);
      chk({tag, "_meta_cyc"}, mon_meta_cyc, hdr_cyc);
    end
  endtask

  initial begin
    int kind, ihl, plen, npay, npad, tlen;
    logic [3:0]  ver;
    logic [7:0]  proto;
    logic [15:0] frag;
    logic [31:0] dst;
    bit crc, flip;

    rst            = 1'b1;
    eth_data_in    = '0;
    eth_byte_valid = 1'b0;
    eth_eof        = 1'b0;
    eth_err        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {ip_data_out, ip_byte_valid, ip_eof, ip_err, ip_meta_valid,
                          ip_src_addr, ip_dst_addr, ip_payload_len}, '0);
    rst = 1'b0;
    idle(2);

    build(4'd4, 4'd5, 28, 8'd17, 16'h0000, LOCAL_IP, 8, 0, 1'b0);
    run_frame("t1_exact", 1'b0, 0);
    build(4'd4, 4'd5, 28, 8'd17, 16'h4000, LOCAL_IP, 8, 18, 1'b0);
    run_frame("t2_padded", 1'b0, 0);
    build(4'd4, 4'd5, 28, 8'd17, 16'h0000, LOCAL_IP, 8, 18, 1'b0);
    run_frame("t3_crc", 1'b1, 0);
    build(4'd4, 4'd5, 28, 8'd17, 16'h0000, LOCAL_IP, 8, 0, 1'b1);
    run_frame("t4_badsum", 1'b0, 0);
    build(4'd4, 4'd5, 28, 8'd17, 16'h0000, LOCAL_IP, 8, 0, 1'b0);
    run_frame("t4_next", 1'b0, 0);
    build(4'd4, 4'd6, 34, 8'd17, 16'h0000, BCAST, 10, 0, 1'b0);
    run_frame("t5_option", 1'b0, 0);
    build(4'd4, 4'd6, 34, 8'd6, 16'h0000, LOCAL_IP, 10, 0, 1'b0);
    run_frame("t5_tcp", 1'b0, 0);
    build(4'd4, 4'd5, 28, 8'd17, 16'h0000, LOCAL_IP, 3, 0, 1'b0);
    run_frame("t6_trunc", 1'b0, 0);

    // Reset in the middle of the payload, then the frame tail arrives in HDR
    build(4'd4, 4'd5, 28, 8'd17, 16'h0000, LOCAL_IP, 8, 0, 1'b0);
    for (int i = 0; i < 24; i++) drive(frm[i], 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    idle(1);
    chk("rst_mid_outputs", {ip_data_out, ip_byte_valid, ip_eof, ip_err, ip_meta_valid,
                            ip_src_addr, ip_dst_addr, ip_payload_len}, '0);
    rst = 1'b0;
    snap();
    for (int i = 24; i < 28; i++) drive(frm[i], 1'b1, i == 27, 1'b0);
    idle(4);
    chk("rst_tail_nerr", mon_nerr - e0, 1);
    chk("rst_tail_nbytes", mon_nbytes - b0, 0);
    chk("rst_tail_nmeta", mon_nmeta - m0, 0);

    for (int k = 0; k < 40; k++) begin
      kind  = $urandom_range(11);
      ihl   = 5 + $urandom_range(2);
      plen  = 1 + $urandom_range(15);
      npay  = plen;
      npad  = ($urandom_range(2) == 0) ? $urandom_range(12) : 0;
      tlen  = ihl * 4 + plen;
      ver   = 4'd4;
      proto = 8'd17;
      frag  = ($urandom_range(1) == 0) ? 16'h4000 : 16'h0000;
      dst   = ($urandom_range(3) == 0) ? BCAST : LOCAL_IP;
      flip  = 1'b0;
      crc   = ($urandom_range(4) == 0);
      case (kind)
        0: ver = 4'd6;
        1: proto = 8'd6;
        2: dst = $urandom;
        3: frag = 16'h2000;
        4: frag = 16'h0010;
        5: flip = 1'b1;
        6: tlen = ihl * 4;
        7: ihl = 4;
        default: ;
      endcase
      if ($urandom_range(4) == 0) begin
        npay = $urandom_range(plen - 1);
        npad = 0;
      end
      build(ver, 4'(ihl), tlen, proto, frag, dst, npay, npad, flip);
      run_frame($sformatf("rnd%0d", k), crc, 20);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
